// File: rtl/time_of_day_counter_if.sv
// Bundle between a time-of-day consumer and its control/status side.
// master: drives tick/run/load/set_time/alarm controls, reads time, strobes and flags.
// slave:  the counter; reads controls, drives time_bcd, strobes, load_err, alarm_out.
interface time_of_day_counter_if;
    logic        sec_tick;
    logic        run;
    logic        load;
    logic [23:0] set_time;
    logic        load_err;
    logic [23:0] time_bcd;
    logic        min_tick;
    logic        hour_tick;
    logic        day_tick;
    logic [23:0] alarm_time;
    logic        alarm_en;
    logic        alarm_clr;
    logic        alarm_out;

    modport master (
        output sec_tick, run, load, set_time, alarm_time, alarm_en, alarm_clr,
        input  load_err, time_bcd, min_tick, hour_tick, day_tick, alarm_out
    );

    modport slave (
        input  sec_tick, run, load, set_time, alarm_time, alarm_en, alarm_clr,
        output load_err, time_bcd, min_tick, hour_tick, day_tick, alarm_out
    );
endinterface

// File: rtl/time_of_day_counter.sv
// 24-hour BCD wall clock (HH:MM:SS) driven by one-second ticks, with
// validated load, minute/hour/day rollover strobes and a sticky alarm.
// Ports: clk100 (rising edge), reset (sync, active high), bus (slave modport):
//   sec_tick/run/load/set_time/alarm_time/alarm_en/alarm_clr in;
//   time_bcd/min_tick/hour_tick/day_tick/load_err/alarm_out out (all registered).
module time_of_day_counter #(
    parameter int unsigned TICKS_PER_SEC = 1
) (
    input logic                  clk100,
    input logic                  reset,
    time_of_day_counter_if.slave bus
);
    localparam logic [7:0] PRESC_MAX = 8'(TICKS_PER_SEC - 1);

    logic [7:0] presc;
    logic [7:0] presc_nxt;
    logic [3:0] s0, s1, m0, m1, h0, h1;
    logic [3:0] s0_nxt, s1_nxt, m0_nxt, m1_nxt, h0_nxt, h1_nxt;
    logic [23:0] time_nxt;
    logic       tick_ok, advance, load_ok;
    logic       sec59, min59, hour23;
    logic       alarm_hit;
    logic       load_err_q, min_q, hour_q, day_q, alarm_q;

    function automatic logic bcd_valid(input logic [23:0] t);
        return (t[3:0]   <= 4'd9) && (t[7:4]   <= 4'd5) &&
               (t[11:8]  <= 4'd9) && (t[15:12] <= 4'd5) &&
               (t[19:16] <= 4'd9) && (t[23:20] <= 4'd2) &&
               !((t[23:20] == 4'd2) && (t[19:16] > 4'd3));
    endfunction

    always_comb begin
        // A tick coinciding with any load is dropped, even a rejected one.
        tick_ok = bus.run && bus.sec_tick && !bus.load;
        advance = tick_ok && (presc == PRESC_MAX);
        load_ok = bus.load && bcd_valid(bus.set_time);

        presc_nxt = presc;
        if (load_ok)
            presc_nxt = 8'd0;
        else if (tick_ok)
            presc_nxt = (presc == PRESC_MAX) ? 8'd0 : presc + 8'd1;

        sec59  = (s1 == 4'd5) && (s0 == 4'd9);
        min59  = (m1 == 4'd5) && (m0 == 4'd9);
        hour23 = (h1 == 4'd2) && (h0 == 4'd3);

        s0_nxt = s0;
        s1_nxt = s1;
        m0_nxt = m0;
        m1_nxt = m1;
        h0_nxt = h0;
        h1_nxt = h1;
        if (advance) begin
            s0_nxt = (s0 == 4'd9) ? 4'd0 : s0 + 4'd1;
            if (s0 == 4'd9)
                s1_nxt = (s1 == 4'd5) ? 4'd0 : s1 + 4'd1;
            if (sec59) begin
                m0_nxt = (m0 == 4'd9) ? 4'd0 : m0 + 4'd1;
                if (m0 == 4'd9)
                    m1_nxt = (m1 == 4'd5) ? 4'd0 : m1 + 4'd1;
            end
            if (sec59 && min59) begin
                // 23 wraps to 00; otherwise H0 carries into H1 at 9.
                if (hour23) begin
                    h0_nxt = 4'd0;
                    h1_nxt = 4'd0;
                end else if (h0 == 4'd9) begin
                    h0_nxt = 4'd0;
                    h1_nxt = h1 + 4'd1;
                end else begin
                    h0_nxt = h0 + 4'd1;
                end
            end
        end
        time_nxt = {h1_nxt, h0_nxt, m1_nxt, m0_nxt, s1_nxt, s0_nxt};

        // Running time is always valid BCD, so an invalid alarm never hits.
        alarm_hit = bus.alarm_en && advance && (time_nxt == bus.alarm_time);
    end

    always_ff @(posedge clk100) begin
        if (reset) begin
            presc      <= 8'd0;
            {h1, h0, m1, m0, s1, s0} <= 24'h000000;
            load_err_q <= 1'b0;
            min_q      <= 1'b0;
            hour_q     <= 1'b0;
            day_q      <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            presc      <= presc_nxt;
            load_err_q <= bus.load && !load_ok;
            min_q      <= advance && sec59;
            hour_q     <= advance && sec59 && min59;
            day_q      <= advance && sec59 && min59 && hour23;
            if (load_ok)
                {h1, h0, m1, m0, s1, s0} <= bus.set_time;
            else if (advance)
                {h1, h0, m1, m0, s1, s0} <= time_nxt;
            // A fresh hit overrides a same-cycle clear.
            alarm_q <= alarm_hit || (alarm_q && !bus.alarm_clr);
        end
    end

    assign bus.time_bcd  = {h1, h0, m1, m0, s1, s0};
    assign bus.load_err  = load_err_q;
    assign bus.min_tick  = min_q;
    assign bus.hour_tick = hour_q;
    assign bus.day_tick  = day_q;
    assign bus.alarm_out = alarm_q;
endmodule

// File: tb/tb_time_of_day_counter.sv
// Directed bench for time_of_day_counter: default instance plus a
// TICKS_PER_SEC=4 instance for the prescaler behaviour.
module tb_time_of_day_counter;
    logic clk100 = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    time_of_day_counter_if bus ();
    time_of_day_counter_if bus4 ();

    time_of_day_counter #(.TICKS_PER_SEC(1)) dut (
        .clk100(clk100), .reset(reset), .bus(bus)
    );
    time_of_day_counter #(.TICKS_PER_SEC(4)) dut4 (
        .clk100(clk100), .reset(reset), .bus(bus4)
    );

    always #5 clk100 = ~clk100;

    task automatic step();
        @(posedge clk100);
        #1;
    endtask

    task automatic tick();
        bus.sec_tick = 1'b1;
        step();
        bus.sec_tick = 1'b0;
    endtask

    task automatic tick4();
        bus4.sec_tick = 1'b1;
        step();
        bus4.sec_tick = 1'b0;
    endtask

    task automatic do_load(input logic [23:0] v);
        bus.load = 1'b1;
        bus.set_time = v;
        step();
        bus.load = 1'b0;
    endtask

    task automatic do_load4(input logic [23:0] v, input logic with_tick);
        bus4.load = 1'b1;
        bus4.set_time = v;
        bus4.sec_tick = with_tick;
        step();
        bus4.load = 1'b0;
        bus4.sec_tick = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        n_cmp++;
        if (bus.time_bcd !== 24'h000000) begin
            n_bad++;
            $display("FAIL reset_time got %h want 000000", bus.time_bcd);
        end
        n_cmp++;
        if ({bus.load_err, bus.min_tick, bus.hour_tick, bus.day_tick,
             bus.alarm_out} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags got %b want 00000",
                     {bus.load_err, bus.min_tick, bus.hour_tick,
                      bus.day_tick, bus.alarm_out});
        end
        n_cmp++;
        if (bus4.time_bcd !== 24'h000000) begin
            n_bad++;
            $display("FAIL reset_time4 got %h want 000000", bus4.time_bcd);
        end
    endtask

    task automatic test_minute();
        int mt_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (i == 59) begin
                n_cmp++;
                if (bus.min_tick !== 1'b1) begin
                    n_bad++;
                    $display("FAIL min_tick_at_60 got %b want 1", bus.min_tick);
                end
            end
            mt_cnt += int'(bus.min_tick);
            step();
            mt_cnt += int'(bus.min_tick);
            step();
            mt_cnt += int'(bus.min_tick);
        end
        n_cmp++;
        if (mt_cnt != 1) begin
            n_bad++;
            $display("FAIL min_tick_count got %0d want 1", mt_cnt);
        end
        n_cmp++;
        if (bus.time_bcd !== 24'h000100) begin
            n_bad++;
            $display("FAIL minute_time got %h want 000100", bus.time_bcd);
        end
    endtask

    task automatic test_day_rollover();
        do_load(24'h235958);
        n_cmp++;
        if (bus.time_bcd !== 24'h235958 || bus.load_err !== 1'b0) begin
            n_bad++;
            $display("FAIL load_235958 got %h err %b want 235958 err 0",
                     bus.time_bcd, bus.load_err);
        end
        tick();
        n_cmp++;
        if (bus.time_bcd !== 24'h235959 || bus.min_tick !== 1'b0) begin
            n_bad++;
            $display("FAIL tick_235959 got %h mt %b want 235959 mt 0",
                     bus.time_bcd, bus.min_tick);
        end
        tick();
        n_cmp++;
        if (bus.time_bcd !== 24'h000000 ||
            {bus.min_tick, bus.hour_tick, bus.day_tick} !== 3'b111) begin
            n_bad++;
            $display("FAIL day_wrap got %h strobes %b want 000000 111",
                     bus.time_bcd, {bus.min_tick, bus.hour_tick, bus.day_tick});
        end
        step();
        n_cmp++;
        if ({bus.min_tick, bus.hour_tick, bus.day_tick} !== 3'b000) begin
            n_bad++;
            $display("FAIL strobe_width got %b want 000",
                     {bus.min_tick, bus.hour_tick, bus.day_tick});
        end
    endtask

    task automatic test_load_validation();
        do_load(24'h246000);
        n_cmp++;
        if (bus.load_err !== 1'b1 || bus.time_bcd !== 24'h000000) begin
            n_bad++;
            $display("FAIL bad_load got err %b time %h want err 1 time 000000",
                     bus.load_err, bus.time_bcd);
        end
        step();
        n_cmp++;
        if (bus.load_err !== 1'b0) begin
            n_bad++;
            $display("FAIL load_err_width got %b want 0", bus.load_err);
        end
        do_load(24'h195959);
        n_cmp++;
        if (bus.time_bcd !== 24'h195959 || bus.load_err !== 1'b0) begin
            n_bad++;
            $display("FAIL load_195959 got %h err %b want 195959 err 0",
                     bus.time_bcd, bus.load_err);
        end
        tick();
        n_cmp++;
        if (bus.time_bcd !== 24'h200000 ||
            {bus.min_tick, bus.hour_tick, bus.day_tick} !== 3'b110) begin
            n_bad++;
            $display("FAIL hour_carry got %h strobes %b want 200000 110",
                     bus.time_bcd, {bus.min_tick, bus.hour_tick, bus.day_tick});
        end
    endtask

    task automatic test_prescaler();
        do_load4(24'h000000, 1'b0);
        tick4();
        tick4();
        do_load4(24'h000010, 1'b1);
        for (int i = 0; i < 3; i++) tick4();
        n_cmp++;
        if (bus4.time_bcd !== 24'h000010) begin
            n_bad++;
            $display("FAIL presc_3_ticks got %h want 000010", bus4.time_bcd);
        end
        tick4();
        n_cmp++;
        if (bus4.time_bcd !== 24'h000011) begin
            n_bad++;
            $display("FAIL presc_4_ticks got %h want 000011", bus4.time_bcd);
        end
        for (int i = 0; i < 3; i++) tick4();
        do_load4(24'h006000, 1'b1);
        n_cmp++;
        if (bus4.time_bcd !== 24'h000011 || bus4.load_err !== 1'b1) begin
            n_bad++;
            $display("FAIL presc_bad_load got %h err %b want 000011 err 1",
                     bus4.time_bcd, bus4.load_err);
        end
        tick4();
        n_cmp++;
        if (bus4.time_bcd !== 24'h000012) begin
            n_bad++;
            $display("FAIL presc_discard got %h want 000012", bus4.time_bcd);
        end
    endtask

    task automatic test_alarm();
        bus.alarm_time = 24'h120001;
        bus.alarm_en = 1'b1;
        do_load(24'h120001);
        n_cmp++;
        if (bus.alarm_out !== 1'b0) begin
            n_bad++;
            $display("FAIL alarm_on_load got %b want 0", bus.alarm_out);
        end
        do_load(24'h120000);
        n_cmp++;
        if (bus.alarm_out !== 1'b0) begin
            n_bad++;
            $display("FAIL alarm_pre got %b want 0", bus.alarm_out);
        end
        tick();
        n_cmp++;
        if (bus.alarm_out !== 1'b1 || bus.time_bcd !== 24'h120001) begin
            n_bad++;
            $display("FAIL alarm_rise got %b time %h want 1 120001",
                     bus.alarm_out, bus.time_bcd);
        end
        bus.alarm_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (bus.alarm_out !== 1'b1) begin
                n_bad++;
                $display("FAIL alarm_hold_%0d got %b want 1", i, bus.alarm_out);
            end
        end
        bus.alarm_clr = 1'b1;
        step();
        bus.alarm_clr = 1'b0;
        n_cmp++;
        if (bus.alarm_out !== 1'b0) begin
            n_bad++;
            $display("FAIL alarm_clr got %b want 0", bus.alarm_out);
        end
        do_load(24'h120000);
        bus.alarm_en = 1'b1;
        do_load(24'h120001);
        do_load(24'h120000);
        tick();
        bus.alarm_clr = 1'b1;
        do_load(24'h120000);
        bus.sec_tick = 1'b1;
        step();
        bus.sec_tick = 1'b0;
        bus.alarm_clr = 1'b0;
        n_cmp++;
        if (bus.alarm_out !== 1'b1) begin
            n_bad++;
            $display("FAIL alarm_clr_vs_set got %b want 1", bus.alarm_out);
        end
        bus.alarm_clr = 1'b1;
        bus.alarm_en = 1'b0;
        step();
        bus.alarm_clr = 1'b0;
    endtask

    task automatic test_run_and_reset();
        do_load(24'h101010);
        bus.run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            step();
        end
        n_cmp++;
        if (bus.time_bcd !== 24'h101010) begin
            n_bad++;
            $display("FAIL run_low got %h want 101010", bus.time_bcd);
        end
        bus.run = 1'b1;
        bus.alarm_time = 24'h101012;
        bus.alarm_en = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (bus.alarm_out !== 1'b1 || bus.time_bcd !== 24'h101012) begin
            n_bad++;
            $display("FAIL pre_reset got %b time %h want 1 101012",
                     bus.alarm_out, bus.time_bcd);
        end
        do_load(24'h235959);
        reset = 1'b1;
        bus.sec_tick = 1'b1;
        bus.load = 1'b1;
        bus.set_time = 24'h123456;
        step();
        reset = 1'b0;
        bus.sec_tick = 1'b0;
        bus.load = 1'b0;
        n_cmp++;
        if (bus.time_bcd !== 24'h000000) begin
            n_bad++;
            $display("FAIL mid_reset_time got %h want 000000", bus.time_bcd);
        end
        n_cmp++;
        if ({bus.load_err, bus.min_tick, bus.hour_tick, bus.day_tick,
             bus.alarm_out} !== 5'b0) begin
            n_bad++;
            $display("FAIL mid_reset_flags got %b want 00000",
                     {bus.load_err, bus.min_tick, bus.hour_tick,
                      bus.day_tick, bus.alarm_out});
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.sec_tick = 1'b0;
        bus.run = 1'b1;
        bus.load = 1'b0;
        bus.set_time = 24'h0;
        bus.alarm_time = 24'h250000;
        bus.alarm_en = 1'b0;
        bus.alarm_clr = 1'b0;
        bus4.sec_tick = 1'b0;
        bus4.run = 1'b1;
        bus4.load = 1'b0;
        bus4.set_time = 24'h0;
        bus4.alarm_time = 24'h250000;
        bus4.alarm_en = 1'b0;
        bus4.alarm_clr = 1'b0;
        test_reset();
        test_minute();
        test_day_rollover();
        test_load_validation();
        test_prescaler();
        test_alarm();
        test_run_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
